spider_wave_scheduler: RTL

Game-flow sequencer for the spider enemy group. Re-arms the spider motion controller at the start of every wave, paces its movement from the frame tick with a per-wave step period, tracks per-spider kill/escape outcomes and lives, and advances waves or ends the game. Sits between the VGA frame timing and collision logic on one side and the spider motion controller on the other, all in the 25 MHz pixel-clock domain.

---
 rtl/spider_wave_scheduler_if.sv | 34 +++
 rtl/spider_wave_scheduler.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/spider_wave_scheduler_if.sv
// spider_wave_scheduler_if
//   Groups the frame/collision inputs and the motion-controller / game-status
//   outputs of spider_wave_scheduler.
//   slave  : scheduler side (samples frame_tick, start, spider_alive,
//            spider_hit; drives reset_spider, motion_en, wave_num, lives,
//            kills, wave_active, game_over)
//   master : environment side (the mirror image)
interface spider_wave_scheduler_if #(
    parameter int unsigned NUM_SPIDERS = 4
);
    logic                   frame_tick;
    logic                   start;
    logic [NUM_SPIDERS-1:0] spider_alive;
    logic [NUM_SPIDERS-1:0] spider_hit;
    logic                   reset_spider;
    logic                   motion_en;
    logic [3:0]             wave_num;
    logic [1:0]             lives;
    logic [7:0]             kills;
    logic                   wave_active;
    logic                   game_over;

    modport master (
        output frame_tick, start, spider_alive, spider_hit,
        input  reset_spider, motion_en, wave_num, lives, kills,
               wave_active, game_over
    );

    modport slave (
        input  frame_tick, start, spider_alive, spider_hit,
        output reset_spider, motion_en, wave_num, lives, kills,
               wave_active, game_over
    );
endinterface

// File: rtl/spider_wave_scheduler.sv
// spider_wave_scheduler
//   Game-flow sequencer for the spider group: re-arms the motion controller
//   each wave, paces motion from the frame tick with a per-wave step period,
//   scores kills/escapes, tracks lives and advances waves or ends the game.
//   Ports:
//     clk25 : 25 MHz pixel clock, all state on its rising edge
//     rst_n : asynchronous active-low reset
//     bus   : spider_wave_scheduler_if.slave (frame_tick, start,
//             spider_alive, spider_hit in; reset_spider, motion_en,
//             wave_num, lives, kills, wave_active, game_over out)
module spider_wave_scheduler #(
    parameter int unsigned NUM_SPIDERS = 4,
    parameter int unsigned BASE_PERIOD = 4,
    parameter int unsigned MIN_PERIOD  = 1,
    parameter int unsigned GAP_FRAMES  = 60,
    parameter int unsigned LIVES_INIT  = 3,
    parameter int unsigned MAX_WAVE    = 15
) (
    input  logic                    clk25,
    input  logic                    rst_n,
    spider_wave_scheduler_if.slave  bus
);
    localparam int unsigned GW = (GAP_FRAMES > 1) ? $clog2(GAP_FRAMES + 1) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, ARM, RUN, GAP, OVER} state_t;

    state_t                 state_q;
    logic [NUM_SPIDERS-1:0] done_q;
    logic [NUM_SPIDERS-1:0] alive_q;
    logic [4:0]             fcnt_q;
    logic [GW-1:0]          gcnt_q;
    logic [3:0]             wave_q;
    logic [1:0]             lives_q;
    logic [7:0]             kills_q;
    logic                   reset_spider_q;
    logic                   motion_en_q;
    logic                   wave_active_q;
    logic                   game_over_q;

    logic [NUM_SPIDERS-1:0] kill_d;
    logic [NUM_SPIDERS-1:0] esc_d;
    logic [NUM_SPIDERS-1:0] done_d;
    logic [8:0]             kills_sum;
    logic [7:0]             kills_d;
    logic [7:0]             esc_cnt;
    logic [1:0]             lives_d;
    logic [4:0]             base5;
    logic [4:0]             wave5;
    logic [4:0]             diff5;
    logic [4:0]             period;
    logic [4:0]             fcnt_inc;
    logic [GW-1:0]          gcnt_inc;

    function automatic logic [7:0] popcount(input logic [NUM_SPIDERS-1:0] v);
        logic [7:0] n;
        n = '0;
        for (int unsigned i = 0; i < NUM_SPIDERS; i++) begin
            n = n + {7'd0, v[i]};
        end
        return n;
    endfunction

    always_comb begin
        // A hit wins over a same-cycle alive falling edge: that spider is a kill.
        kill_d    = bus.spider_hit & ~done_q;
        esc_d     = alive_q & ~bus.spider_alive & ~bus.spider_hit & ~done_q;
        done_d    = done_q | kill_d | esc_d;
        kills_sum = {1'b0, kills_q} + {1'b0, popcount(kill_d)};
        kills_d   = kills_sum[8] ? 8'hFF : kills_sum[7:0];
        esc_cnt   = popcount(esc_d);
        lives_d   = (esc_cnt >= {6'd0, lives_q}) ? 2'd0 : (lives_q - esc_cnt[1:0]);
        // Step period without underflow when wave_num exceeds BASE_PERIOD.
        base5     = 5'(BASE_PERIOD);
        wave5     = {1'b0, wave_q};
        diff5     = base5 - wave5;
        period    = ((base5 > wave5) && (diff5 > 5'(MIN_PERIOD))) ? diff5 : 5'(MIN_PERIOD);
        fcnt_inc  = fcnt_q + 5'd1;
        gcnt_inc  = gcnt_q + GW'(1);
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            done_q         <= '0;
            alive_q        <= '0;
            fcnt_q         <= '0;
            gcnt_q         <= '0;
            wave_q         <= '0;
            lives_q        <= 2'(LIVES_INIT);
            kills_q        <= '0;
            reset_spider_q <= 1'b0;
            motion_en_q    <= 1'b0;
            wave_active_q  <= 1'b0;
            game_over_q    <= 1'b0;
        end else begin
            reset_spider_q <= 1'b0;
            motion_en_q    <= 1'b0;
            unique case (state_q)
                IDLE, OVER: begin
                    if (bus.start) begin
                        state_q        <= LOAD;
                        reset_spider_q <= 1'b1;
                        wave_q         <= '0;
                        lives_q        <= 2'(LIVES_INIT);
                        kills_q        <= '0;
                        done_q         <= '0;
                        fcnt_q         <= '0;
                        game_over_q    <= 1'b0;
                    end
                end
                LOAD: begin
                    state_q <= ARM;
                end
                ARM: begin
                    // Sample the freshly reloaded flags so stale lows from the
                    // previous wave never look like escapes.
                    alive_q       <= bus.spider_alive;
                    state_q       <= RUN;
                    wave_active_q <= 1'b1;
                end
                RUN: begin
                    alive_q <= bus.spider_alive;
                    done_q  <= done_d;
                    kills_q <= kills_d;
                    lives_q <= lives_d;
                    if (bus.frame_tick) begin
                        if (fcnt_inc >= period) begin
                            motion_en_q <= 1'b1;
                            fcnt_q      <= '0;
                        end else begin
                            fcnt_q <= fcnt_inc;
                        end
                    end
                    if (lives_d == 2'd0) begin
                        state_q       <= OVER;
                        wave_active_q <= 1'b0;
                        game_over_q   <= 1'b1;
                    end else if (&done_d) begin
                        state_q       <= GAP;
                        wave_active_q <= 1'b0;
                        gcnt_q        <= '0;
                        if (wave_q < 4'(MAX_WAVE)) begin
                            wave_q <= wave_q + 4'd1;
                        end
                    end
                end
                GAP: begin
                    if (bus.frame_tick) begin
                        if (gcnt_inc >= GW'(GAP_FRAMES)) begin
                            state_q        <= LOAD;
                            reset_spider_q <= 1'b1;
                            done_q         <= '0;
                            fcnt_q         <= '0;
                        end else begin
                            gcnt_q <= gcnt_inc;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.reset_spider = reset_spider_q;
    assign bus.motion_en    = motion_en_q;
    assign bus.wave_num     = wave_q;
    assign bus.lives        = lives_q;
    assign bus.kills        = kills_q;
    assign bus.wave_active  = wave_active_q;
    assign bus.game_over    = game_over_q;
endmodule
